// File: rtl/scu_dsp_dma_ctrl_if.sv
// rtl/scu_dsp_dma_ctrl_if.sv - external word-bus interface between the DSP DMA engine and the bus fabric
interface scu_dsp_dma_ctrl_if #(
  parameter int ADDR_W = 25
);
  logic [ADDR_W+1:0] bus_a;
  logic [31:0]       bus_do;
  logic [31:0]       bus_di;
  logic              bus_we;
  logic              bus_req;
  logic              bus_ack;

  modport master (
    output bus_a, bus_do, bus_we, bus_req,
    input  bus_di, bus_ack
  );

  modport slave (
    input  bus_a, bus_do, bus_we, bus_req,
    output bus_di, bus_ack
  );
endinterface

// File: rtl/scu_dsp_dma_ctrl.sv
// rtl/scu_dsp_dma_ctrl.sv - SCU DSP bus-side DMA engine
// Owns RA0/WA0, the transfer address counter and the bus-timeout watchdog.
module scu_dsp_dma_ctrl #(
  parameter int ADDR_W = 25,
  parameter int TO_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic [31:0] dso,
  input  logic        ra0w,
  input  logic        wa0w,
  input  logic        dmaw,
  input  logic        dma_req,
  input  logic        dma_run,
  input  logic        dma_last,
  input  logic        dma_we,
  input  logic [31:0] dma_do,
  output logic [31:0] dma_di,
  output logic        dma_ack,
  output logic        dma_end,
  output logic        err,
  scu_dsp_dma_ctrl_if.master bus
);

  localparam int TO_W = $clog2(TO_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BUS, S_ACK, S_GAP, S_END} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ra0;
  logic [ADDR_W-1:0] wa0;
  logic [ADDR_W-1:0] cnt;
  logic [2:0]        add_r;
  logic              hold_r;
  logic [2:0]        add_a;
  logic              hold_a;
  logic              dir;
  logic              lastf;
  logic              gap_armed;
  logic [TO_W-1:0]   to_cnt;
  logic [ADDR_W+1:0] bus_a_r;
  logic [31:0]       bus_do_r;
  logic              bus_we_r;
  logic              bus_req_r;
  logic [ADDR_W-1:0] inc;
  logic [ADDR_W-1:0] start_addr;
  logic              unused_dso;

  assign inc        = (add_a == 3'd0) ? '0 : (ADDR_W'(1) << (add_a - 3'd1));
  assign start_addr = dma_we ? wa0 : ra0;
  assign unused_dso = ^dso[31:ADDR_W];

  assign bus.bus_a   = bus_a_r;
  assign bus.bus_do  = bus_do_r;
  assign bus.bus_we  = bus_we_r;
  assign bus.bus_req = bus_req_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ra0       <= '0;
      wa0       <= '0;
      cnt       <= '0;
      add_r     <= '0;
      hold_r    <= 1'b0;
      add_a     <= '0;
      hold_a    <= 1'b0;
      dir       <= 1'b0;
      lastf     <= 1'b0;
      gap_armed <= 1'b0;
      to_cnt    <= '0;
      bus_a_r   <= '0;
      bus_do_r  <= '0;
      bus_we_r  <= 1'b0;
      bus_req_r <= 1'b0;
      dma_di    <= '0;
      dma_ack   <= 1'b0;
      dma_end   <= 1'b0;
      err       <= 1'b0;
    end else if (ce) begin
      if (dmaw) begin
        add_r  <= dso[17:15];
        hold_r <= dso[14];
      end

      case (state)
        S_IDLE: begin
          if (dma_run && dma_req) state <= S_START;
        end

        // The active transfer runs on its own copy of ADD/HOLD.
        S_START: begin
          cnt    <= start_addr;
          dir    <= dma_we;
          err    <= 1'b0;
          to_cnt <= '0;
          add_a  <= add_r;
          hold_a <= hold_r;
          if (!dma_run) begin
            dma_end <= 1'b1;
            state   <= S_END;
          end else begin
            bus_req_r <= 1'b1;
            bus_we_r  <= dma_we;
            bus_a_r   <= {start_addr, 2'b00};
            bus_do_r  <= dma_do;
            state     <= S_BUS;
          end
        end

        S_BUS: begin
          if (bus.bus_ack) begin
            if (!dir) dma_di <= bus.bus_di;
            cnt       <= cnt + inc;
            lastf     <= dma_last;
            bus_req_r <= 1'b0;
            bus_we_r  <= 1'b0;
            dma_ack   <= 1'b1;
            state     <= S_ACK;
          end else if (to_cnt == TO_W'(TO_CYC - 1)) begin
            bus_req_r <= 1'b0;
            bus_we_r  <= 1'b0;
            err       <= 1'b1;
            dma_end   <= 1'b1;
            state     <= S_END;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        S_ACK: begin
          dma_ack <= 1'b0;
          if (lastf || !dma_run) begin
            dma_end <= 1'b1;
            state   <= S_END;
          end else begin
            gap_armed <= 1'b0;
            state     <= S_GAP;
          end
        end

        // First GAP cycle ignores DMA_REQ so a request still high from the
        // previous word cannot start a second bus cycle.
        S_GAP: begin
          gap_armed <= 1'b1;
          if (!dma_run) begin
            dma_end <= 1'b1;
            state   <= S_END;
          end else if (gap_armed && dma_req) begin
            bus_req_r <= 1'b1;
            bus_we_r  <= dir;
            bus_a_r   <= {cnt, 2'b00};
            bus_do_r  <= dma_do;
            to_cnt    <= '0;
            state     <= S_BUS;
          end
        end

        S_END: begin
          dma_end <= 1'b0;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase

      if (state == S_END && !hold_a) begin
        if (dir) wa0 <= cnt;
        else     ra0 <= cnt;
      end
      if (ra0w) ra0 <= dso[ADDR_W-1:0];
      if (wa0w) wa0 <= dso[ADDR_W-1:0];
    end
  end

endmodule
